// File: rtl/mem_dump_if.sv
// Bus bundle between the dump engine and its surroundings: control handshake,
// SPRAM read port and UART transmit handshake.
interface mem_dump_if #(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              hex_mode;
    logic              repeat_en;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [7:0]        mem_data_out;
    logic              tx_start;
    logic [7:0]        tx_char;
    logic              tx_busy;

    // Engine side.
    modport slave (
        input  start, base_addr, length, hex_mode, repeat_en, abort,
        input  mem_data_out, tx_busy,
        output busy, done, mem_addr, mem_write, tx_start, tx_char
    );

    // Controller / memory / UART side.
    modport master (
        output start, base_addr, length, hex_mode, repeat_en, abort,
        output mem_data_out, tx_busy,
        input  busy, done, mem_addr, mem_write, tx_start, tx_char
    );
endinterface

// File: rtl/mem_dump.sv
// Memory-dump engine: walks a byte range of the SPRAM and streams it to the
// UART as raw bytes or as uppercase hex text with line breaks.
module mem_dump #(
    parameter int ADDR_W     = 15,
    parameter int LEN_W      = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic      clk,
    input  logic      rst,
    mem_dump_if.slave bus
);
    localparam int LINE_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_EMIT,
        S_ACK,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic              r_hex;
    logic              r_rep;
    logic              r_abort;
    logic [LINE_W-1:0] r_line;
    logic [7:0]        r_byte;
    logic [1:0]        r_ci;
    logic              r_ack_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_tx_start;
    logic [7:0]        r_tx_char;

    logic              w_more;
    logic              w_eol;
    logic              w_abort;
    logic              w_last_char;
    logic [3:0]        w_nib;
    logic [7:0]        w_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character selection within the current byte; r_ci counts characters:
    // hex = high nibble, low nibble, space or CR, LF.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_more      = (r_idx + LEN_W'(1)) < r_len;
        w_eol       = !w_more || (r_line == LINE_W'(LINE_BYTES - 1));
        w_abort     = r_abort || bus.abort;
        w_nib       = (r_ci == 2'd0) ? r_byte[7:4] : r_byte[3:0];
        w_char      = r_byte;
        w_last_char = 1'b1;
        if (r_hex) begin
            unique case (r_ci)
                2'd0, 2'd1: w_char = hex_ascii(w_nib);
                2'd2:       w_char = w_eol ? 8'h0D : 8'h20;
                default:    w_char = 8'h0A;
            endcase
            w_last_char = (r_ci == 2'd3) || ((r_ci == 2'd2) && !w_eol);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_hex      <= 1'b0;
            r_rep      <= 1'b0;
            r_abort    <= 1'b0;
            r_line     <= '0;
            r_byte     <= '0;
            r_ci       <= '0;
            r_ack_cnt  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_char  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_tx_start <= 1'b0;
            if (r_busy && bus.abort)
                r_abort <= 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (bus.start) begin
                        r_base <= bus.base_addr;
                        r_len  <= bus.length;
                        r_hex  <= bus.hex_mode;
                        r_rep  <= bus.repeat_en;
                        r_addr <= bus.base_addr;
                        r_idx  <= '0;
                        r_line <= '0;
                        if (bus.length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_ADDR;
                        end
                    end
                end

                S_ADDR: r_state <= S_READ;

                S_READ: begin
                    r_byte <= bus.mem_data_out;
                    r_ci   <= '0;
                    if (w_abort) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (!bus.tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_char  <= w_char;
                        r_ack_cnt  <= 1'b0;
                        r_state    <= S_ACK;
                    end
                end

                // Bounded wait so a UART that never raises tx_busy cannot hang us.
                S_ACK: begin
                    if (bus.tx_busy || r_ack_cnt)
                        r_state <= S_DRAIN;
                    else
                        r_ack_cnt <= 1'b1;
                end

                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (w_abort) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (!w_last_char) begin
                            r_ci    <= r_ci + 2'd1;
                            r_state <= S_EMIT;
                        end else begin
                            r_line <= w_eol ? '0 : r_line + LINE_W'(1);
                            if (w_more) begin
                                r_idx   <= r_idx + LEN_W'(1);
                                r_addr  <= r_addr + ADDR_W'(1);
                                r_state <= S_ADDR;
                            end else if (r_rep) begin
                                r_idx   <= '0;
                                r_addr  <= r_base;
                                r_line  <= '0;
                                r_state <= S_ADDR;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_write = 1'b0;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_char   = r_tx_char;
endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: SPRAM and UART models plus a byte-stream
// reference model computed directly from the dump formatting rules.
module tb_mem_dump;
    localparam int ADDR_W     = 15;
    localparam int LEN_W      = 16;
    localparam int LINE_BYTES = 2;
    localparam int MEM_SIZE   = 1 << ADDR_W;
    localparam int RX_DEPTH   = 4096;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_dump_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    mem_dump #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .LINE_BYTES(LINE_BYTES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // SPRAM model: registered read.
    logic [7:0] mem [0:MEM_SIZE-1];
    always @(posedge clk) bus.mem_data_out <= mem[bus.mem_addr];

    // UART model and output monitors.
    int         frame_len  = 3;
    bit         uart_dead  = 1'b0;
    int         frame_left = 0;
    logic [7:0] rx_buf [0:RX_DEPTH-1];
    int         rx_n       = 0;
    int         done_cnt   = 0;
    int         proto_err  = 0;

    always @(posedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if ((bus.done && bus.busy) || (bus.tx_start && bus.tx_busy))
            proto_err <= proto_err + 1;
        if (rst) begin
            bus.tx_busy <= 1'b0;
            frame_left  <= 0;
        end else if (bus.tx_start) begin
            rx_buf[rx_n % RX_DEPTH] <= bus.tx_char;
            rx_n <= rx_n + 1;
            if (!uart_dead) begin
                bus.tx_busy <= 1'b1;
                frame_left  <= frame_len;
            end
        end else if (frame_left > 1) begin
            frame_left <= frame_left - 1;
        end else if (frame_left == 1) begin
            frame_left  <= 0;
            bus.tx_busy <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model and helpers ----------------
    function automatic bq_t model_dump(input int base, input int len, input bit hx);
        bq_t        q;
        string      digits = "0123456789ABCDEF";
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = mem[(base + k) % MEM_SIZE];
            if (!hx) begin
                q.push_back(b);
            end else begin
                q.push_back(digits[b[7:4]]);
                q.push_back(digits[b[3:0]]);
                if (((k + 1) % LINE_BYTES == 0) || (k == len - 1)) begin
                    q.push_back(8'h0D);
                    q.push_back(8'h0A);
                end else begin
                    q.push_back(8'h20);
                end
            end
        end
        return q;
    endfunction

    function automatic bq_t str_q(input string s);
        bq_t q;
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        return q;
    endfunction

    function automatic bq_t rx_slice(input int from, input int to);
        bq_t q;
        for (int k = from; k < to; k++) q.push_back(rx_buf[k % RX_DEPTH]);
        return q;
    endfunction

    function automatic int first_diff(input bq_t a, input bq_t b);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int k = 0; k < n; k++) if (a[k] !== b[k]) return k;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic string q_str(input bq_t q);
        string s;
        s = "";
        for (int k = 0; k < q.size() && k < 40; k++) s = {s, $sformatf("%02h ", q[k])};
        return s;
    endfunction

    function automatic logic [ADDR_W-1:0] a_of(input int a);
        return ADDR_W'(a % MEM_SIZE);
    endfunction

    task automatic pulse_start(input int b, input int l, input bit hx, input bit rp);
        @(negedge clk);
        bus.base_addr = ADDR_W'(b);
        bus.length    = LEN_W'(l);
        bus.hex_mode  = hx;
        bus.repeat_en = rp;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_cnt > d0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_rx(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rx_n >= target) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_tx_busy(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus.tx_busy === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Runs a non-repeating dump and checks completion, stream contents and a single done.
    task automatic dump_and_check(input string name, input int b, input int l, input bit hx,
                                  input bq_t exp);
        int  s0, d0, pos;
        bit  ok;
        bq_t got;
        s0 = rx_n;
        d0 = done_cnt;
        pulse_start(b, l, hx, 1'b0);
        wait_done(d0, 3000, ok);
        repeat (5) @(negedge clk);
        got = rx_slice(s0, rx_n);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen, got=%0d pulses required=1", name, done_cnt - d0);
        end
        n_tests++;
        pos = first_diff(got, exp);
        if (pos != -1) begin
            n_fail++;
            $display("FAIL %s_stream: differs at %0d, got=[%s] required=[%s]", name, pos, q_str(got), q_str(exp));
        end
        n_tests++;
        if ((done_cnt - d0) !== 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: got done_pulses=%0d busy=%b required 1 and 0", name, done_cnt - d0, bus.busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b done=%b tx_start=%b required 0 0 0", bus.busy, bus.done, bus.tx_start);
        end
        n_tests++;
        if (bus.tx_char !== 8'h00 || bus.mem_addr !== '0 || bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: got tx_char=%h mem_addr=%h mem_write=%b required 00 0000 0", bus.tx_char, bus.mem_addr, bus.mem_write);
        end
        rst = 1'b0;
    endtask

    task automatic test_raw();
        for (int k = 0; k < 4; k++) mem[k] = 8'(8'h41 + k);
        frame_len = 4;
        dump_and_check("raw", 0, 4, 1'b0, str_q("ABCD"));
    endtask

    task automatic test_hex_line();
        mem[10] = 8'h00;
        mem[11] = 8'hAF;
        mem[12] = 8'h5C;
        frame_len = 2;
        dump_and_check("hex_line", 10, 3, 1'b1, str_q("00 AF\r\n5C\r\n"));
    endtask

    task automatic test_wrap();
        bq_t exp;
        mem[a_of(32'h7FFE)] = 8'h11;
        mem[a_of(32'h7FFF)] = 8'h22;
        mem[0]              = 8'h33;
        exp = {8'h11, 8'h22, 8'h33};
        frame_len = 1;
        dump_and_check("wrap", 32'h7FFE, 3, 1'b0, exp);
    endtask

    task automatic test_zero_len();
        int s0, d0, busy_seen;
        s0 = rx_n;
        d0 = done_cnt;
        busy_seen = 0;
        pulse_start(5, 0, 1'b1, 1'b0);
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: got done=%b busy=%b required 1 0", bus.done, bus.busy);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) busy_seen++;
        end
        n_tests++;
        if (busy_seen != 0 || rx_n != s0 || (done_cnt - d0) != 1) begin
            n_fail++;
            $display("FAIL zero_len_quiet: got busy_cycles=%0d tx=%0d done=%0d required 0 0 1", busy_seen, rx_n - s0, done_cnt - d0);
        end
    endtask

    task automatic test_busy_start();
        int  s0, d0, pos;
        bit  ok, ok2;
        bq_t got, exp;
        for (int k = 0; k < 3; k++) mem[32'h20 + k] = 8'($urandom);
        exp = model_dump(32'h20, 3, 1'b0);
        frame_len = 3;
        s0 = rx_n;
        d0 = done_cnt;
        pulse_start(32'h20, 3, 1'b0, 1'b0);
        wait_rx(s0 + 1, 200, ok);
        pulse_start(32'h40, 5, 1'b1, 1'b1);
        wait_done(d0, 2000, ok2);
        repeat (5) @(negedge clk);
        got = rx_slice(s0, rx_n);
        n_tests++;
        pos = first_diff(got, exp);
        if (!ok || !ok2 || pos != -1) begin
            n_fail++;
            $display("FAIL busy_start: got=[%s] required=[%s] (started=%b done=%b)", q_str(got), q_str(exp), ok, ok2);
        end
        n_tests++;
        if ((done_cnt - d0) !== 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_done: got done_pulses=%0d busy=%b required 1 0", done_cnt - d0, bus.busy);
        end
    endtask

    task automatic test_repeat_abort();
        int  s0, d0, n_abort, pos;
        bit  ok, ok2, ok3;
        bq_t got, exp;
        mem[32'h50] = 8'h41;
        mem[32'h51] = 8'h42;
        frame_len = 3;
        s0 = rx_n;
        d0 = done_cnt;
        pulse_start(32'h50, 2, 1'b0, 1'b1);
        wait_rx(s0 + 5, 500, ok);
        wait_tx_busy(50, ok2);
        n_tests++;
        if (!ok || !ok2 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL repeat_running: got tx=%0d done_pulses=%0d required >=5 and 0", rx_n - s0, done_cnt - d0);
        end
        n_abort   = rx_n;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done(d0, 200, ok3);
        repeat (30) @(negedge clk);
        n_tests++;
        if (!ok3 || (done_cnt - d0) !== 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: got done_pulses=%0d busy=%b required 1 0", done_cnt - d0, bus.busy);
        end
        n_tests++;
        if (rx_n != n_abort) begin
            n_fail++;
            $display("FAIL abort_no_more_tx: got %0d chars after abort required 0", rx_n - n_abort);
        end
        got = rx_slice(s0, rx_n);
        for (int k = 0; k < got.size(); k++) exp.push_back((k % 2 == 0) ? 8'h41 : 8'h42);
        n_tests++;
        pos = first_diff(got, exp);
        if (pos != -1) begin
            n_fail++;
            $display("FAIL repeat_stream: differs at %0d got=[%s] required=[%s]", pos, q_str(got), q_str(exp));
        end
    endtask

    task automatic test_ack_timeout();
        for (int k = 0; k < 3; k++) mem[32'h200 + k] = 8'($urandom);
        uart_dead = 1'b1;
        dump_and_check("ack_timeout", 32'h200, 3, 1'b0, model_dump(32'h200, 3, 1'b0));
        uart_dead = 1'b0;
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        for (int k = 0; k < 4; k++) mem[32'h100 + k] = 8'($urandom);
        frame_len = 6;
        pulse_start(32'h100, 4, 1'b0, 1'b0);
        wait_tx_busy(100, ok);
        @(negedge clk);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (!ok || bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b tx_start=%b mem_addr=%h (reached_drain=%b) required 0 0 0000", bus.busy, bus.tx_start, bus.mem_addr, ok);
        end
        repeat (20) @(negedge clk);
        n_tests++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d done pulses required 0", done_cnt - d0);
        end
        dump_and_check("after_reset", 32'h100, 4, 1'b0, model_dump(32'h100, 4, 1'b0));
    endtask

    task automatic test_random();
        int b, l;
        bit hx;
        for (int t = 0; t < 10; t++) begin
            b  = int'($urandom_range(0, MEM_SIZE - 1));
            if (t == 0) b = MEM_SIZE - 2;
            l  = int'($urandom_range(1, 7));
            hx = 1'($urandom_range(0, 1));
            frame_len = int'($urandom_range(1, 5));
            for (int k = 0; k < l; k++) mem[(b + k) % MEM_SIZE] = 8'($urandom);
            dump_and_check($sformatf("random%0d", t), b, l, hx, model_dump(b, l, hx));
        end
    endtask

    task automatic test_protocol();
        n_tests++;
        if (proto_err != 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d tx_start-while-busy or done-while-busy events required 0", proto_err);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.hex_mode  = 1'b0;
        bus.repeat_en = 1'b0;
        bus.abort     = 1'b0;
        test_reset();
        test_raw();
        test_hex_line();
        test_wrap();
        test_zero_len();
        test_busy_start();
        test_repeat_abort();
        test_ack_timeout();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_dump.md
# mem_dump

Parametrised memory-dump engine that reads a programmable byte range from the SPRAM `mem` block and streams it to `uart_tx`, either as raw bytes or as formatted hex text. It sits between `mem` and `uart_tx` under `top` and replaces hand-written fetch/transmit state machines in `top`. Added behaviour: programmable base and length, a hex/line-formatting mode, repeat mode, abort, and an explicit done/busy handshake.

## Interface

- `ADDR_W`, 15: width of the memory byte address.
- `LEN_W`, 16: width of the length field, so up to 2^LEN_W−1 bytes per dump.
- `LINE_BYTES`, 16: bytes per output line in hex mode; must be ≥ 1.

Ports:

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `base_addr`  in  ADDR_W  first byte address; sampled on an honoured `start`.
- `length`  in  LEN_W  byte count; sampled on an honoured `start`.
- `hex_mode`  in  1  0 = raw bytes, 1 = hex text; sampled on an honoured `start`.
- `repeat_en`  in  1  1 = restart at `base_addr` after the last byte; sampled on an honoured `start`.
- `abort`  in  1  stop after the character currently in flight.
- `busy`  out  1  high whenever not IDLE.
- `done`  out  1  one-cycle pulse on completion or abort.
- `mem_addr`  out  ADDR_W  registered read address to `mem`.
- `mem_write`  out  1  tied 0.
- `mem_data_out`  in  8  read data from `mem`; valid one cycle after `mem_addr` is stable.
- `tx_start`  out  1  one-cycle pulse to `uart_tx`.
- `tx_char`  out  8  character to send; held stable from `tx_start` until the next `tx_start`.
- `tx_busy`  in  1  from `uart_tx`; rises the cycle after `tx_start`.

## Operation

- State machine states:
  - **IDLE**: wait for `start`.
  - **ADDR**: `mem_addr` is stable.
  - **READ**: capture `mem_data_out` into `byte_q`.
  - **EMIT**: present the next character and pulse `tx_start`.
  - **ACK**: wait for `tx_busy` = 1.
  - **DRAIN**: wait for `tx_busy` = 0.
- IDLE with `start`:
  - Latch the parameters, set `mem_addr` = `base_addr`, clear the byte index `i` and the line counter.
  - If `length` = 0, pulse `done` and stay in IDLE.
  - Otherwise go to ADDR.
- Byte address is `(base_addr + i) mod 2^ADDR_W`; the address wraps silently.
- Path through the states per byte: ADDR → READ → one or more EMIT/ACK/DRAIN rounds, one round per character.
- Characters per byte in raw mode: `byte_q` only.
- Characters per byte in hex mode:
  - Upper nibble, then lower nibble, each mapped 0–9 → "0"–"9" and A–F → "A"–"F" (uppercase).
  - Then a separator:
    - After the LINE_BYTES-th byte of a line, or after the last byte of the dump: CR (0x0D) then LF (0x0A). The line counter resets after each CR/LF.
    - Otherwise: space (0x20).
- After the last character of a byte, leaving DRAIN:
  - If `i + 1 < length`: increment `i`, advance `mem_addr`, go to ADDR.
  - Else if the latched repeat is set: `i` = 0, `mem_addr` = `base_addr`, line counter = 0, go to ADDR; `done` is not pulsed.
  - Else: pulse `done`, go to IDLE.
- EMIT waits while `tx_busy` = 1. It never asserts `tx_start` while `tx_busy` is high.
- `abort`:
  - Sticky once seen while `busy` is high.
  - Checked when leaving DRAIN or READ: pulse `done`, go to IDLE; no CR/LF is appended.
  - An abort asserted in EMIT/ACK lets the in-flight character complete.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: `start` wins and the abort is discarded.

## Timing

- Values on reset: `busy` = 0, `done` = 0, `tx_start` = 0, `tx_char` = 0, `mem_addr` = 0, `mem_write` = 0, state = IDLE, sticky abort cleared.
- `rst` mid-dump returns to IDLE within one cycle, with no `done` pulse.
- `busy` rises the cycle after an honoured `start`.
- `start` to first `tx_start`: 3 cycles minimum (ADDR, READ, EMIT) when `tx_busy` = 0.
- Per character: 1 cycle EMIT + ≥ 1 cycle ACK + the UART frame time in DRAIN.
- If `tx_busy` has not risen within 2 cycles in ACK, the FSM proceeds to DRAIN; this timeout prevents a lock-up.
- `done` is asserted in the same cycle that `busy` falls.
- `length` = 0: `done` pulses the cycle after `start`; `busy` never rises.

## Test plan

- Raw dump: `mem` preloaded 0x41..0x44 at 0..3, `base_addr`=0, `length`=4, `hex_mode`=0 → UART emits "ABCD", then `done` pulses once and `busy` falls.
- Hex with line break: `LINE_BYTES`=2, bytes 0x00,0xAF,0x5C at 10..12, `length`=3 → "00 AF\r\n5C\r\n", 11 `tx_start` pulses.
- Address wrap: `ADDR_W`=15, `base_addr`=0x7FFE, `length`=3 → reads 0x7FFE, 0x7FFF, 0x0000 in that order.
- Repeat and abort: `length`=2, `repeat_en`=1 → "ABAB…" with no `done`; assert `abort` mid-frame → the current character completes, `done` pulses, and no further `tx_start` follows.
- Zero length and busy start: `length`=0 → `done` the next cycle, no TX. `start` pulsed during an active dump → ignored, output unchanged.
- Reset mid-operation: `rst` during DRAIN → next cycle `busy`=0, `tx_start`=0, `mem_addr`=0, no `done`; a subsequent `start` dumps correctly.
